// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR write unit: addresses, op encodings,
// field bit positions, write masks and read-image helpers.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIP_MSIP     = 3;
  localparam int unsigned MIP_MTIP     = 7;
  localparam int unsigned MIP_MEIP     = 11;

  localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
  localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

  // MPP is hardwired to machine mode, so it always reads 2'b11.
  function automatic logic [31:0] mstatus_image(input logic mie, input logic mpie);
    return {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
  endfunction

  function automatic logic [31:0] mip_image(input logic meip, input logic mtip,
                                            input logic msip);
    logic [31:0] img;
    img           = '0;
    img[MIP_MEIP] = meip;
    img[MIP_MTIP] = mtip;
    img[MIP_MSIP] = msip;
    return img;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with separately writable halves; a write to either
// half suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_lo) begin
      count[31:0] <= wr_data;
    end else if (wr_hi) begin
      count[63:32] <= wr_data;
    end else if (inc_en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_write_unit.sv
// Machine-mode CSR file, write side: read mux, CSRRW/RS/RC update, trap/MRET
// state, mcycle/minstret counters and interrupt-pending generation.
module csr_write_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        csr_wr_en_in,
  input  logic [1:0]  csr_op_in,
  input  logic [11:0] csr_addr_in,
  input  logic [31:0] pre_data_in,
  input  logic        instret_inc_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_cause_in,
  input  logic [31:0] trap_pc_in,
  input  logic [31:0] trap_val_in,
  input  logic        mret_in,
  input  logic        meip_in,
  input  logic        mtip_in,
  input  logic        msip_in,
  output logic [31:0] csr_rdata_out,
  output logic        illegal_csr_out,
  output logic [31:0] mepc_out,
  output logic [31:0] mtvec_out,
  output logic        irq_pending_out
);

  logic        st_mie, st_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [63:0] mcycle, minstret;
  logic [31:0] old_val, new_val;
  logic        addr_legal, wr_active;
  logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  csr_op_e     op;

  assign op = csr_op_e'(csr_op_in);

  always_comb begin
    addr_legal = 1'b1;
    old_val    = '0;
    case (csr_addr_in)
      CSR_MSTATUS:   old_val = mstatus_image(st_mie, st_mpie);
      CSR_MISA:      old_val = MISA_VAL;
      CSR_MIE:       old_val = mie_q;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MTVAL:     old_val = mtval_q;
      CSR_MIP:       old_val = mip_q;
      CSR_MCYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH: old_val = minstret[63:32];
      default:       addr_legal = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_RW:  new_val = pre_data_in;
      CSR_RS:  new_val = old_val | pre_data_in;
      CSR_RC:  new_val = old_val & ~pre_data_in;
      default: new_val = old_val;
    endcase
  end

  // Set/clear with a zero operand is a pure read and must not disturb the CSR.
  assign wr_active = csr_wr_en_in && addr_legal && (op != CSR_NOP) &&
                     ((op == CSR_RW) || (pre_data_in != '0));

  assign wr_mstatus  = wr_active && (csr_addr_in == CSR_MSTATUS);
  assign wr_mie      = wr_active && (csr_addr_in == CSR_MIE);
  assign wr_mtvec    = wr_active && (csr_addr_in == CSR_MTVEC);
  assign wr_mscratch = wr_active && (csr_addr_in == CSR_MSCRATCH);
  assign wr_mepc     = wr_active && (csr_addr_in == CSR_MEPC);
  assign wr_mcause   = wr_active && (csr_addr_in == CSR_MCAUSE);
  assign wr_mtval    = wr_active && (csr_addr_in == CSR_MTVAL);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
    end else if (trap_taken_in) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_in) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr_mstatus) begin
      st_mie  <= new_val[MSTATUS_MIE];
      st_mpie <= new_val[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_taken_in) begin
      mepc_q   <= trap_pc_in & ALIGN4_MASK;
      mcause_q <= trap_cause_in;
      mtval_q  <= trap_val_in;
    end else begin
      if (wr_mepc)   mepc_q   <= new_val & ALIGN4_MASK;
      if (wr_mcause) mcause_q <= new_val;
      if (wr_mtval)  mtval_q  <= new_val;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mip_q      <= '0;
    end else begin
      if (wr_mie)      mie_q      <= new_val & MIE_WMASK;
      if (wr_mtvec)    mtvec_q    <= new_val & ALIGN4_MASK;
      if (wr_mscratch) mscratch_q <= new_val;
      mip_q <= mip_image(meip_in, mtip_in, msip_in);
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .inc_en  (1'b1),
    .wr_lo   (wr_active && (csr_addr_in == CSR_MCYCLE)),
    .wr_hi   (wr_active && (csr_addr_in == CSR_MCYCLEH)),
    .wr_data (new_val),
    .count   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .inc_en  (instret_inc_in),
    .wr_lo   (wr_active && (csr_addr_in == CSR_MINSTRET)),
    .wr_hi   (wr_active && (csr_addr_in == CSR_MINSTRETH)),
    .wr_data (new_val),
    .count   (minstret)
  );

  assign csr_rdata_out   = old_val;
  assign illegal_csr_out = csr_wr_en_in && !addr_legal;
  assign mepc_out        = mepc_q;
  assign mtvec_out       = mtvec_q;
  assign irq_pending_out = st_mie && |(mip_q & mie_q);

endmodule
